// File: rtl/func_msg_sched.sv
// rtl/func_msg_sched.sv - SHA-256 message schedule: 16-word load, 64-round W/K stream
module func_msg_sched (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_load_valid,
    input  logic [31:0] in_load_word,
    output logic        out_load_ready,
    output logic        out_valid,
    input  logic        in_ready,
    output logic [31:0] out_Wi,
    output logic [31:0] out_Ki,
    output logic [5:0]  out_index,
    output logic        out_last
);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    state_t      state_q, state_d;
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];
    logic [3:0]  cnt_q, cnt_d;
    logic [5:0]  round_q, round_d;
    logic        load_acc;
    logic        run_hs;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

    assign load_acc = (state_q == ST_LOAD) && in_load_valid;
    assign run_hs   = (state_q == ST_RUN) && in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        round_d = round_q;
        win_d   = win_q;
        if (load_acc) begin
            for (int i = 0; i < 15; i++) begin
                win_d[i] = win_q[i+1];
            end
            win_d[15] = in_load_word;
            cnt_d     = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
                state_d = ST_RUN;
                round_d = 6'd0;
            end
        end
        if (run_hs) begin
            // Window holds W[round..round+15]; the new tail word is W[round+16].
            for (int i = 0; i < 15; i++) begin
                win_d[i] = win_q[i+1];
            end
            win_d[15] = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
            round_d   = round_q + 6'd1;
            if (round_q == 6'd63) begin
                state_d = ST_LOAD;
            end
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q <= ST_LOAD;
            cnt_q   <= 4'd0;
            round_q <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= 32'd0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            round_q <= round_d;
            win_q   <= win_d;
        end
    end

    assign out_load_ready = (state_q == ST_LOAD);
    assign out_valid      = (state_q == ST_RUN);
    assign out_Wi         = win_q[0];
    assign out_Ki         = K_ROM[round_q];
    assign out_index      = round_q;
    assign out_last       = (state_q == ST_RUN) && (round_q == 6'd63);

endmodule

// File: tb/tb_func_msg_sched.sv
// tb/tb_func_msg_sched.sv - directed self-checking bench for func_msg_sched
module tb_func_msg_sched;

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic        in_load_valid;
    logic [31:0] in_load_word;
    logic        out_load_ready;
    logic        out_valid;
    logic        in_ready;
    logic [31:0] out_Wi;
    logic [31:0] out_Ki;
    logic [5:0]  out_index;
    logic        out_last;

    func_msg_sched dut (
        .in_clk         (in_clk),
        .in_rst         (in_rst),
        .in_load_valid  (in_load_valid),
        .in_load_word   (in_load_word),
        .out_load_ready (out_load_ready),
        .out_valid      (out_valid),
        .in_ready       (in_ready),
        .out_Wi         (out_Wi),
        .out_Ki         (out_Ki),
        .out_index      (out_index),
        .out_last       (out_last)
    );

    always #5 in_clk = ~in_clk;

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] blk   [16];
    logic [31:0] exp_w [64];
    logic        blk_is_abc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic build_model();
        for (int t = 0; t < 16; t++) exp_w[t] = blk[t];
        for (int t = 16; t < 64; t++) begin
            exp_w[t] = (ror(exp_w[t-2], 17) ^ ror(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
                     + exp_w[t-7]
                     + (ror(exp_w[t-15], 7) ^ ror(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
                     + exp_w[t-16];
        end
    endtask

    task automatic set_abc();
        for (int j = 0; j < 16; j++) blk[j] = 32'd0;
        blk[0]     = 32'h61626380;
        blk[15]    = 32'h00000018;
        blk_is_abc = 1'b1;
        build_model();
    endtask

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic load_block(input int nwords, input bit gaps);
        for (int j = 0; j < nwords; j++) begin
            if (gaps) begin
                int idle = $urandom_range(0, 3);
                for (int g = 0; g < idle; g++) begin
                    in_load_valid = 1'b0;
                    in_load_word  = $urandom;
                    tick();
                    check_val("gap_no_valid", {31'd0, out_valid}, 32'd0);
                end
            end
            in_load_valid = 1'b1;
            in_load_word  = blk[j];
            check_val("load_ready", {31'd0, out_load_ready}, 32'd1);
            check_val("load_no_valid", {31'd0, out_valid}, 32'd0);
            tick();
        end
        in_load_valid = 1'b0;
    endtask

    // mode 0: ready high; 1: 3-cycle stall at t=20 then toggle; 2: junk loads during run; 3: stop at t=30
    task automatic run_stream(input int mode);
        int   t     = 0;
        int   cyc   = 0;
        int   stall = 0;
        logic tog   = 1'b1;
        logic rdy;
        while (t < 64 && cyc < 400) begin
            if (mode == 3 && t == 30) break;
            check_val("run_valid", {31'd0, out_valid}, 32'd1);
            check_val("run_index", {26'd0, out_index}, t[31:0]);
            check_val("run_wi", out_Wi, exp_w[t]);
            check_val("run_ki", out_Ki, K_TAB[t]);
            check_val("run_last", {31'd0, out_last}, {31'd0, t == 63});
            check_val("run_no_load_ready", {31'd0, out_load_ready}, 32'd0);
            if (blk_is_abc) begin
                if (t == 0)  check_val("abc_w0", out_Wi, 32'h61626380);
                if (t == 15) check_val("abc_w15", out_Wi, 32'h00000018);
                if (t == 16) check_val("abc_w16", out_Wi, 32'h61626380);
                if (t == 17) check_val("abc_w17", out_Wi, 32'h000f0000);
            end
            if (mode == 1 && t >= 20) begin
                if (stall < 3) begin
                    rdy = 1'b0;
                    stall++;
                end else begin
                    rdy = tog;
                    tog = ~tog;
                end
            end else begin
                rdy = 1'b1;
            end
            if (mode == 2) begin
                in_load_valid = 1'b1;
                in_load_word  = $urandom;
            end
            in_ready = rdy;
            tick();
            if (rdy) t++;
            cyc++;
        end
        in_ready      = 1'b0;
        in_load_valid = 1'b0;
        if (mode != 3) begin
            check_val("run_count", t[31:0], 32'd64);
            check_val("post_valid", {31'd0, out_valid}, 32'd0);
            check_val("post_load_ready", {31'd0, out_load_ready}, 32'd1);
        end else begin
            check_val("reached_t30", t[31:0], 32'd30);
        end
    endtask

    task automatic pulse_reset(input string tag);
        in_rst = 1'b1;
        tick();
        in_rst = 1'b0;
        check_val({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check_val({tag, "_load_ready"}, {31'd0, out_load_ready}, 32'd1);
        check_val({tag, "_index"}, {26'd0, out_index}, 32'd0);
        check_val({tag, "_last"}, {31'd0, out_last}, 32'd0);
    endtask

    initial begin
        in_rst        = 1'b1;
        in_load_valid = 1'b0;
        in_load_word  = 32'd0;
        in_ready      = 1'b0;
        blk_is_abc    = 1'b0;
        tick();
        pulse_reset("reset");

        set_abc();
        load_block(16, 1'b0);
        run_stream(0);

        load_block(16, 1'b0);
        run_stream(1);

        load_block(16, 1'b1);
        run_stream(0);

        load_block(16, 1'b0);
        run_stream(2);

        for (int j = 0; j < 16; j++) blk[j] = 32'd0;
        blk_is_abc = 1'b0;
        build_model();
        load_block(16, 1'b0);
        run_stream(0);

        set_abc();
        load_block(16, 1'b0);
        run_stream(3);
        pulse_reset("rst_mid_run");
        load_block(16, 1'b0);
        run_stream(0);

        load_block(7, 1'b0);
        pulse_reset("rst_mid_load");
        load_block(16, 1'b0);
        run_stream(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/func_msg_sched.md
Name: func_msg_sched

Overview:
- Produces the per-round SHA-256 operands W_t and K_t (t = 0..63) consumed by the round datapath: the T1 adder uses Wi/Ki, and the T2/state update uses the same round index.
- Accepts one 512-bit message block as 16 serial 32-bit words over a valid/ready load port.
- Expands the block with a 16-word sliding window and streams 64 (W_t, K_t, t) triples over a valid/ready output port.
- Sits between the block buffer/padder and the compression round engine.

Parameters:
- none (word width 32, 16 load words and 64 rounds are fixed by SHA-256)

Ports:
- in_clk  input  1  single clock; all state updates on rising edge
- in_rst  input  1  synchronous, active-high reset
- in_load_valid  input  1  load word present
- in_load_word  input  32  message word M_j, big-endian word order (j = 0 first)
- out_load_ready  output  1  block can accept a load word
- out_valid  output  1  out_Wi/out_Ki/out_index valid
- in_ready  input  1  round engine consumes the current triple
- out_Wi  output  32  W_t
- out_Ki  output  32  K_t (FIPS 180-4 constant table, internal 64x32 ROM)
- out_index  output  6  round index t
- out_last  output  1  high with out_valid when t == 63

Behaviour:
- State:
  - FSM {LOAD, RUN}
  - window w[0..15] of 32-bit registers
  - 4-bit load count
  - 6-bit round counter
- Reset (in_rst high at an edge):
  - state = LOAD; load count, round counter and all window words = 0
  - out_load_ready = 1, out_valid = 0, out_index = 0, out_last = 0
  - Reset mid-load or mid-run discards the block entirely; no partial output follows.
- LOAD:
  - out_load_ready = 1, out_valid = 0.
  - Accept when in_load_valid && out_load_ready: shift the window down (w[i] <= w[i+1]), w[15] <= in_load_word, count++.
  - On the 16th accept: state <= RUN, round <= 0, count <= 0.
  - After that edge, w[i] = M_i.
- RUN:
  - out_load_ready = 0; in_load_valid is ignored, no stall and no corruption.
  - out_valid = 1, out_Wi = w[0], out_Ki = K[round], out_index = round, out_last = (round == 63). All outputs are driven from registers only; no combinational path from in_ready.
  - Handshake (out_valid && in_ready):
    - window shifts: w[i] <= w[i+1]
    - w[15] <= sig1(w[14]) + w[9] + sig0(w[1]) + w[0], mod 2^32
    - round++
  - Invariant: w[i] = W_{round+i}.
- Small sigma functions:
  - sig0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x)
  - sig1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x)
  - These are the lowercase schedule functions, not the round-function Sigma.
- Expansion for rounds 48..63 is computed but unused. This is harmless and needs no gating.
- Backpressure: while in_ready = 0 the window, round and all outputs hold exactly.
- Last round: handshake at round 63 -> state <= LOAD, round <= 0, out_valid falls next cycle, out_load_ready rises next cycle. There is no bubble beyond that single edge.
- Latency:
  - first out_valid is the cycle after the 16th load accept
  - with in_ready held high, 64 consecutive cycles of output
  - full block = 16 load + 64 run cycles
- No simultaneous load and run: the next block's words are accepted only after out_last is consumed.

Test Plan:
- "abc" padded block (M0 = 0x61626380, M1..M14 = 0, M15 = 0x00000018), in_ready = 1:
  - t = 0 out_Wi = 0x61626380, out_Ki = 0x428a2f98
  - t = 15 out_Wi = 0x00000018
  - t = 16 out_Wi = 0x61626380
  - t = 17 out_Wi = 0x000f0000
  - t = 63 out_Ki = 0xc67178f2, out_last = 1
  - all 64 W_t match the software model
- Backpressure: same block, drop in_ready for 3 cycles at t = 20, and toggle in_ready every cycle thereafter -> no skipped or repeated index; W/K/index stable while stalled; 64 handshakes total.
- Load gaps: in_load_valid with random idle cycles between words -> identical W stream to the gapless case; out_valid never asserts before the 16th accept.
- in_load_valid held high with new data during RUN -> words ignored, out_load_ready = 0, stream unchanged. After out_last is consumed, out_load_ready = 1 and a second block (all-zero words) yields W16 = 0, W17 = 0 and K restarting at 0x428a2f98.
- Reset mid-run (t = 30) and reset mid-load (after 7 words) -> next cycle out_valid = 0, out_load_ready = 1. A subsequent full "abc" load produces the correct stream from t = 0.
